// File: rtl/ulpi_phy_responder.sv
// PHY-side ULPI emulator: divides clk into ulpi_clk, owns dir/nxt, captures link
// TX transfers for a local sink and injects local RX packets as RXCMD/data sequences.
module ulpi_phy_responder #(
  parameter int         CLK_DIV      = 4,
  parameter int         RX_GAP       = 1,
  parameter int         MAX_TX_BYTES = 66,
  parameter logic [7:0] RXCMD_ACTIVE = 8'h1D,
  parameter logic [7:0] RXCMD_END    = 8'h0D
) (
  input  logic       clk,
  input  logic       n_rst,
  output logic       ulpi_clk,
  input  logic [7:0] ulpi_data_in,
  output logic [7:0] ulpi_data_out,
  input  logic       stp,
  output logic       dir,
  output logic       nxt,
  input  logic       pkt_valid,
  input  logic [7:0] pkt_byte,
  input  logic       pkt_last,
  output logic       pkt_ready,
  output logic [7:0] tx_cmd,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  output logic [9:0] tx_count,
  output logic       tx_done,
  output logic       tx_overflow,
  output logic       rx_done,
  output logic       busy
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = (RX_GAP > 0) ? $clog2(RX_GAP + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  typedef enum logic [3:0] {
    IDLE, TX_ACK, TX_DATA, TX_END,
    RX_TURN, RX_CMD, RX_DATA, RX_END, RX_RELEASE, RX_TURNBACK
  } state_t;

  state_t           state_r;
  logic [DIV_W-1:0] div_cnt_r;
  logic             ulpi_clk_r;
  logic             dir_r;
  logic             nxt_r;
  logic [7:0]       data_out_r;
  logic             pkt_ready_r;
  logic [7:0]       tx_cmd_r;
  logic [7:0]       tx_byte_r;
  logic             tx_valid_r;
  logic [9:0]       tx_count_r;
  logic             tx_done_r;
  logic             tx_overflow_r;
  logic             rx_done_r;
  logic [GAP_W-1:0] gap_cnt_r;
  logic             rise_tick_s;
  logic             fall_tick_s;
  logic [9:0]       tx_count_next_s;
  logic             tx_over_next_s;

  assign rise_tick_s = (div_cnt_r == DIV_W'(0));
  assign fall_tick_s = (div_cnt_r == DIV_HALF);

  // Interface clock divider; ulpi_clk is registered from the next count
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt_r  <= DIV_W'(0);
      ulpi_clk_r <= 1'b0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r  <= DIV_W'(0);
      ulpi_clk_r <= 1'b1;
    end else begin
      div_cnt_r  <= div_cnt_r + DIV_W'(1);
      ulpi_clk_r <= ((div_cnt_r + DIV_W'(1)) < DIV_HALF);
    end
  end

  // Saturating TX byte count and the overflow flag it would produce
  always_comb begin
    tx_count_next_s = tx_count_r;
    if (tx_count_r != 10'h3FF) begin
      tx_count_next_s = tx_count_r + 10'd1;
    end else begin
      tx_count_next_s = tx_count_r;
    end
    tx_over_next_s = ({22'd0, tx_count_next_s} > 32'(MAX_TX_BYTES));
  end

  // Protocol state machine; link inputs sampled on rise_tick, bus outputs move on fall_tick
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r       <= IDLE;
      dir_r         <= 1'b0;
      nxt_r         <= 1'b0;
      data_out_r    <= 8'h00;
      pkt_ready_r   <= 1'b0;
      tx_cmd_r      <= 8'h00;
      tx_byte_r     <= 8'h00;
      tx_valid_r    <= 1'b0;
      tx_count_r    <= 10'd0;
      tx_done_r     <= 1'b0;
      tx_overflow_r <= 1'b0;
      rx_done_r     <= 1'b0;
      gap_cnt_r     <= GAP_W'(0);
    end else begin
      pkt_ready_r <= 1'b0;
      tx_valid_r  <= 1'b0;
      tx_done_r   <= 1'b0;
      rx_done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rise_tick_s) begin
            if (ulpi_data_in[7:6] == 2'b01) begin
              tx_cmd_r      <= ulpi_data_in;
              tx_count_r    <= 10'd0;
              tx_overflow_r <= 1'b0;
              state_r       <= TX_ACK;
            end else if (pkt_valid) begin
              state_r <= RX_TURN;
            end
          end
        end
        TX_ACK: begin
          if (fall_tick_s) begin
            nxt_r   <= 1'b1;
            state_r <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (rise_tick_s) begin
            if (stp) begin
              state_r <= TX_END;
            end else if (nxt_r) begin
              tx_byte_r  <= ulpi_data_in;
              tx_valid_r <= 1'b1;
              tx_count_r <= tx_count_next_s;
              if (tx_over_next_s) tx_overflow_r <= 1'b1;
            end
          end
        end
        TX_END: begin
          if (fall_tick_s) begin
            nxt_r     <= 1'b0;
            tx_done_r <= 1'b1;
            state_r   <= IDLE;
          end
        end
        RX_TURN: begin
          if (fall_tick_s) begin
            dir_r      <= 1'b1;
            nxt_r      <= 1'b0;
            data_out_r <= 8'h00;
            state_r    <= RX_CMD;
          end
        end
        RX_CMD: begin
          if (fall_tick_s) begin
            data_out_r <= RXCMD_ACTIVE;
            nxt_r      <= 1'b0;
            gap_cnt_r  <= GAP_W'(0);
            state_r    <= RX_DATA;
          end
        end
        RX_DATA: begin
          if (fall_tick_s) begin
            if (gap_cnt_r != GAP_W'(0)) begin
              data_out_r <= RXCMD_ACTIVE;
              nxt_r      <= 1'b0;
              gap_cnt_r  <= gap_cnt_r - GAP_W'(1);
            end else if (pkt_valid) begin
              data_out_r  <= pkt_byte;
              nxt_r       <= 1'b1;
              pkt_ready_r <= 1'b1;
              gap_cnt_r   <= GAP_W'(RX_GAP);
              if (pkt_last) state_r <= RX_END;
            end else begin
              data_out_r <= RXCMD_ACTIVE;
              nxt_r      <= 1'b0;
            end
          end
        end
        RX_END: begin
          // Trailing RX_GAP cycles of RXCMD_ACTIVE, then RxActive drops
          if (fall_tick_s) begin
            nxt_r <= 1'b0;
            if (gap_cnt_r != GAP_W'(0)) begin
              data_out_r <= RXCMD_ACTIVE;
              gap_cnt_r  <= gap_cnt_r - GAP_W'(1);
            end else begin
              data_out_r <= RXCMD_END;
              state_r    <= RX_RELEASE;
            end
          end
        end
        RX_RELEASE: begin
          if (fall_tick_s) begin
            dir_r      <= 1'b0;
            nxt_r      <= 1'b0;
            data_out_r <= 8'h00;
            state_r    <= RX_TURNBACK;
          end
        end
        RX_TURNBACK: begin
          if (fall_tick_s) begin
            rx_done_r <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          dir_r      <= 1'b0;
          nxt_r      <= 1'b0;
          data_out_r <= 8'h00;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign ulpi_clk      = ulpi_clk_r;
  assign dir           = dir_r;
  assign nxt           = nxt_r;
  assign ulpi_data_out = data_out_r;
  assign pkt_ready     = pkt_ready_r;
  assign tx_cmd        = tx_cmd_r;
  assign tx_byte       = tx_byte_r;
  assign tx_valid      = tx_valid_r;
  assign tx_count      = tx_count_r;
  assign tx_done       = tx_done_r;
  assign tx_overflow   = tx_overflow_r;
  assign rx_done       = rx_done_r;
  assign busy          = (state_r != IDLE);

endmodule
